sevenseg_scan_capture: RTL and testbench
========================================

Name: sevenseg_scan_capture

Overview:
- Reads back a time-multiplexed, active-low 7-segment display bus (`seg_L`/`anode_L`) as driven by the lab display blocks, and recovers the hex value shown on each digit.
- Used as an on-board checker and loopback monitor: display outputs are wired back into this block, and its recovered digits are compared against the switch values.
- Performs synchronisation, dwell-based glitch rejection, segment-to-hex decoding, per-digit validity, and a frame/stale monitor.

Parameters:
- NDIG, 4, number of digits (anodes) observed.
- STABLE_CYC, 4, cycles an (anode, seg) pair must hold before it is captured; legal range 1..255.
- TIMEOUT_CYC, 1023, cycles with no capture before `stale` asserts; legal range 1..65535.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `seg_L`  in  7  segment cathodes, active low, bit order {g,f,e,d,c,b,a}.
- `anode_L`  in  NDIG  digit enables, active low; bit i selects digit i.
- `digits`  out  4*NDIG  recovered hex values; nibble i = digit i.
- `digit_valid`  out  NDIG  nibble i holds a legally decoded value.
- `pattern_err`  out  NDIG  last capture on digit i was an unrecognised pattern.
- `frame_done`  out  1  one-cycle pulse when every digit has been captured since the last pulse.
- `stale`  out  1  no capture for TIMEOUT_CYC cycles.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (`rst_n`).
  - All outputs return to 0, including `digits`, `digit_valid`, `pattern_err`, `frame_done` and `stale`.
  - Synchroniser flops reset to all-ones (display inactive).
  - FSM returns to IDLE; counters and the seen-mask clear.
  - Reset asserted mid-dwell discards the pending capture.
- Input path: `seg_L` and `anode_L` pass through a 2-flop synchroniser, then are inverted to active-high `seg`/`an`.
- FSM states:
  - IDLE: `an` is not one-hot (zero or multiple bits set). Go to SETTLE when `an` becomes one-hot; the dwell counter loads 1.
  - SETTLE: the dwell counter increments each cycle while the synced pair is unchanged.
    - A pair change to another one-hot pair restarts SETTLE with the counter at 1.
    - A change to a non-one-hot `an` goes to IDLE.
    - When the counter equals STABLE_CYC, capture occurs on that edge and the FSM moves to HELD.
  - HELD: no further capture. A pair change goes to SETTLE (counter 1) or IDLE, as above.
- Latency: a new pin pair held steady is reflected on the outputs at clock edge STABLE_CYC+2, counting the first edge at which sync stage 1 samples it. With default parameters this is edge 6.
- Decode table (active-high hex):
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 27=7, 7F=8, 6F=9, 67=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
- Capture on digit i, by pattern:
  - Pattern in the decode table: `digits[i]` takes the code, `digit_valid[i]`=1, `pattern_err[i]`=0.
  - `seg`=00 (blank): `digit_valid[i]`=0, `pattern_err[i]`=0, `digits[i]` holds.
  - Any other pattern: `digit_valid[i]`=0, `pattern_err[i]`=1, `digits[i]` holds.
- Frame monitor: any capture on digit i sets seen[i].
  - When seen becomes all-ones, `frame_done` pulses for exactly the next cycle and seen clears on that same edge.
  - A capture landing on the clearing edge is counted in the new mask.
- Stale monitor: the idle counter resets on every capture and saturates.
  - When it reaches TIMEOUT_CYC, `stale`=1 and all `digit_valid` bits clear; `digits` and `pattern_err` hold.
  - The next capture clears `stale` on the same edge as it updates its digit.
- Width rules: the dwell counter is 8 bits and the idle counter is 16 bits; neither wraps. `digits` nibbles are never partially updated.

Test Plan:
1. Reset release with pins idle (`anode_L`=1111, `seg_L`=7F): all outputs 0, FSM in IDLE, `stale` asserts after 1023 cycles.
2. Hold `anode_L`=1110 with `seg_L`=~4F (=30) from edge 0: `digits[3:0]`=3 and `digit_valid[0]`=1 at edge 6, not at edge 5; holding longer produces no second capture.
3. Scan digits 0..3 with patterns 06, 27, 77, 5E, 40 cycles each: `digits`=16'hDA71, `digit_valid`=1111, and a single `frame_done` pulse one cycle after the digit-3 capture.
4. Glitch: digit 1 shows 6D for 3 cycles, then 7D held: only 6 is captured, and 5 never appears in `digits[7:4]`.
5. Illegal and blank: digit 2 driven with 55, then 00: `pattern_err[2]`=1 with `digit_valid[2]`=0 and the prior nibble held, then `pattern_err[2]`=0 after the blank.
6. Reset and stale edges: `anode_L`=1100 for 50 cycles gives no capture; `rst_n` pulsed low at dwell cycle 3 gives no capture and outputs 0; stale recovery clears `stale` on the first capture edge.

Source files
------------

// File: rtl/sevenseg_scan_capture.sv
// sevenseg_scan_capture
//   Monitors a time-multiplexed, active-low 7-segment display bus and recovers
//   the hex value shown on each digit. A (anode, segment) pair must stay steady
//   for STABLE_CYC cycles before it is captured. This rejects the short
//   transients that occur while the scanner switches from one digit to the next.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_L        segment cathodes, active low, {g,f,e,d,c,b,a}
//   anode_L      digit enables, active low, bit i = digit i
//   digits       recovered hex values, nibble i = digit i
//   digit_valid  nibble i holds a legally decoded value
//   pattern_err  last capture on digit i was an unrecognised pattern
//   frame_done   one-cycle pulse once every digit has been captured
//   stale        no capture for TIMEOUT_CYC cycles
module sevenseg_scan_capture #(
  parameter int NDIG        = 4,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_L,
  input  logic [NDIG-1:0]   anode_L,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   digit_valid,
  output logic [NDIG-1:0]   pattern_err,
  output logic              frame_done,
  output logic              stale
);

  localparam logic [7:0]  STABLE_W  = 8'(STABLE_CYC);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  // Returns {legal, blank, code}.
  function automatic logic [5:0] decode(input logic [6:0] s);
    logic [5:0] r;
    r = 6'b00_0000;
    case (s)
      7'h3F: r = {2'b10, 4'h0};
      7'h06: r = {2'b10, 4'h1};
      7'h5B: r = {2'b10, 4'h2};
      7'h4F: r = {2'b10, 4'h3};
      7'h66: r = {2'b10, 4'h4};
      7'h6D: r = {2'b10, 4'h5};
      7'h7D: r = {2'b10, 4'h6};
      7'h07: r = {2'b10, 4'h7};
      7'h27: r = {2'b10, 4'h7};
      7'h7F: r = {2'b10, 4'h8};
      7'h6F: r = {2'b10, 4'h9};
      7'h67: r = {2'b10, 4'h9};
      7'h77: r = {2'b10, 4'hA};
      7'h7C: r = {2'b10, 4'hB};
      7'h39: r = {2'b10, 4'hC};
      7'h5E: r = {2'b10, 4'hD};
      7'h79: r = {2'b10, 4'hE};
      7'h71: r = {2'b10, 4'hF};
      7'h00: r = {2'b01, 4'h0};
      default: r = 6'b00_0000;
    endcase
    return r;
  endfunction

  logic [6:0]      seg_l_p0, seg_l_p1;
  logic [NDIG-1:0] an_l_p0, an_l_p1;
  logic [6:0]      seg, seg_prev;
  logic [NDIG-1:0] an, an_prev;
  state_t          state;
  logic [7:0]      dwell;
  logic [15:0]     idle_cnt;
  logic [NDIG-1:0] seen;

  logic            one_hot;
  logic            pair_changed;
  logic            capture;
  logic [NDIG-1:0] cap_mask;
  logic [5:0]      dec;
  logic [15:0]     idle_sat;

  // Stage p1 -> decode: active-high view of the synchronised pins.
  assign seg          = ~seg_l_p1;
  assign an           = ~an_l_p1;
  assign one_hot      = $onehot(an);
  assign pair_changed = (seg != seg_prev) || (an != an_prev);
  // The dwell counter counts the current cycle too, so a match with STABLE_CYC
  // on an unchanged pair means the pair has been seen STABLE_CYC+1 times.
  assign capture      = (state == SETTLE) && !pair_changed && (dwell == STABLE_W);
  assign cap_mask     = capture ? an : '0;
  assign dec          = decode(seg);
  assign idle_sat     = (idle_cnt == TIMEOUT_W) ? idle_cnt : idle_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_l_p0    <= '1;
      seg_l_p1    <= '1;
      an_l_p0     <= '1;
      an_l_p1     <= '1;
      seg_prev    <= '0;
      an_prev     <= '0;
      state       <= IDLE;
      dwell       <= '0;
      idle_cnt    <= '0;
      seen        <= '0;
      digits      <= '0;
      digit_valid <= '0;
      pattern_err <= '0;
      frame_done  <= 1'b0;
      stale       <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchroniser on the raw pins.
      seg_l_p0 <= seg_L;
      seg_l_p1 <= seg_l_p0;
      an_l_p0  <= anode_L;
      an_l_p1  <= an_l_p0;
      seg_prev <= seg;
      an_prev  <= an;

      // Dwell FSM: dwell never runs past STABLE_CYC, so it cannot wrap.
      case (state)
        IDLE: begin
          if (one_hot) begin
            state <= SETTLE;
            dwell <= 8'd1;
          end
        end
        SETTLE, HELD: begin
          if (pair_changed) begin
            if (one_hot) begin
              state <= SETTLE;
              dwell <= 8'd1;
            end else begin
              state <= IDLE;
            end
          end else if (state == SETTLE) begin
            if (dwell == STABLE_W) state <= HELD;
            else                   dwell <= dwell + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Capture and stale monitor.
      if (capture) begin
        idle_cnt <= '0;
        stale    <= 1'b0;
        for (int i = 0; i < NDIG; i++) begin
          if (cap_mask[i]) begin
            if (dec[5]) begin
              digits[4*i +: 4] <= dec[3:0];
              digit_valid[i]   <= 1'b1;
              pattern_err[i]   <= 1'b0;
            end else begin
              digit_valid[i]   <= 1'b0;
              pattern_err[i]   <= ~dec[4];
            end
          end
        end
      end else begin
        idle_cnt <= idle_sat;
        if (idle_sat == TIMEOUT_W) begin
          stale       <= 1'b1;
          digit_valid <= '0;
        end
      end

      // Frame monitor: a capture on the clearing edge seeds the new mask.
      if (&seen) begin
        frame_done <= 1'b1;
        seen       <= cap_mask;
      end else begin
        frame_done <= 1'b0;
        seen       <= seen | cap_mask;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
module tb_sevenseg_scan_capture;

  localparam int NDIG = 4;
  localparam int STABLE_CYC = 4;
  localparam int TIMEOUT_CYC = 1023;

  localparam logic [6:0] PAT [18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h27,
                                       7'h7F, 7'h6F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [3:0] VAL [18] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h7,
                                       4'h8, 4'h9, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  logic              clk;
  logic              rst_n;
  logic [6:0]        seg_L;
  logic [NDIG-1:0]   anode_L;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   digit_valid;
  logic [NDIG-1:0]   pattern_err;
  logic              frame_done;
  logic              stale;

  int tests = 0;
  int fails = 0;

  sevenseg_scan_capture #(
    .NDIG(NDIG), .STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg_L(seg_L), .anode_L(anode_L),
    .digits(digits), .digit_valid(digit_valid), .pattern_err(pattern_err),
    .frame_done(frame_done), .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the pins as seen two edges late, a run length of how many
  // consecutive edges that view has been unchanged, and a capture when a
  // one-hot view has been seen exactly STABLE_CYC+1 times in a row.
  logic [6:0]        h1_seg, h2_seg, last_seg;
  logic [NDIG-1:0]   h1_an, h2_an, last_an;
  int                run, idle;
  logic [NDIG-1:0]   seen_m;
  logic [4*NDIG-1:0] exp_digits;
  logic [NDIG-1:0]   exp_valid, exp_perr;
  logic              exp_fd, exp_stale;

  int                m_run_n, m_idle_n;
  logic              m_cap, m_legal;
  logic [3:0]        m_code;
  logic [NDIG-1:0]   m_capmask;

  always_comb begin
    m_legal = 1'b0;
    m_code  = 4'h0;
    for (int k = 0; k < 18; k++) begin
      if (PAT[k] == h2_seg) begin
        m_legal = 1'b1;
        m_code  = VAL[k];
      end
    end
    if (h2_seg == last_seg && h2_an == last_an) m_run_n = (run < 1000) ? run + 1 : run;
    else                                        m_run_n = 1;
    m_cap     = ($countones(h2_an) == 1) && (m_run_n == STABLE_CYC + 1);
    m_capmask = m_cap ? h2_an : '0;
    m_idle_n  = (idle >= TIMEOUT_CYC) ? TIMEOUT_CYC : idle + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_seg <= '0; h2_seg <= '0; last_seg <= '0;
      h1_an  <= '0; h2_an  <= '0; last_an  <= '0;
      run <= 0; idle <= 0; seen_m <= '0;
      exp_digits <= '0; exp_valid <= '0; exp_perr <= '0;
      exp_fd <= 1'b0; exp_stale <= 1'b0;
    end else begin
      h1_seg <= ~seg_L;  h1_an <= ~anode_L;
      h2_seg <= h1_seg;  h2_an <= h1_an;
      last_seg <= h2_seg; last_an <= h2_an;
      run <= m_run_n;
      if (m_cap) begin
        idle <= 0;
        exp_stale <= 1'b0;
        for (int i = 0; i < NDIG; i++) begin
          if (h2_an[i]) begin
            if (m_legal) begin
              exp_digits[4*i +: 4] <= m_code;
              exp_valid[i] <= 1'b1;
              exp_perr[i]  <= 1'b0;
            end else begin
              exp_valid[i] <= 1'b0;
              exp_perr[i]  <= (h2_seg != 7'h00);
            end
          end
        end
      end else begin
        idle <= m_idle_n;
        if (m_idle_n == TIMEOUT_CYC) begin
          exp_stale <= 1'b1;
          exp_valid <= '0;
        end
      end
      if (seen_m == '1) begin
        exp_fd <= 1'b1;
        seen_m <= m_capmask;
      end else begin
        exp_fd <= 1'b0;
        seen_m <= seen_m | m_capmask;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] an_l, input logic [6:0] pattern);
    anode_L = an_l;
    seg_L   = ~pattern;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'b1111, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(4'b1111, 7'h00);
    tests++;
    if ({digits, digit_valid, pattern_err, frame_done, stale} !== 26'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", {digits, digit_valid, pattern_err, frame_done, stale});
    end
    for (int c = 1; c < TIMEOUT_CYC; c++) step();
    tests++;
    if (stale !== 1'b0) begin
      fails++;
      $display("FAIL stale_early: got %b required 0 after %0d cycles", stale, TIMEOUT_CYC - 1);
    end
    step();
    tests++;
    if (stale !== 1'b1) begin
      fails++;
      $display("FAIL stale_on_time: got %b required 1 after %0d cycles", stale, TIMEOUT_CYC);
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int c = 0; c < 3; c++) step();
    drive(4'b1110, 7'h4F);
    for (int e = 0; e <= 12; e++) begin
      step();
      if (e == 5) begin
        tests++;
        if (digit_valid[0] !== 1'b0) begin
          fails++;
          $display("FAIL latency_edge5: valid0 got %b required 0", digit_valid[0]);
        end
      end
      if (e == 6) begin
        tests++;
        if (digit_valid[0] !== 1'b1 || digits[3:0] !== 4'h3) begin
          fails++;
          $display("FAIL latency_edge6: valid0=%b digit0=%h required 1 and 3", digit_valid[0], digits[3:0]);
        end
      end
      tests++;
      if ({digits, digit_valid, pattern_err, frame_done, stale} !== {exp_digits, exp_valid, exp_perr, exp_fd, exp_stale}) begin
        fails++;
        $display("FAIL latency_model e=%0d: got %h required %h", e,
                 {digits, digit_valid, pattern_err, frame_done, stale}, {exp_digits, exp_valid, exp_perr, exp_fd, exp_stale});
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0] pats [4];
    int pulses;
    pats = '{7'h06, 7'h27, 7'h77, 7'h5E};
    pulses = 0;
    do_reset();
    for (int d = 0; d < 4; d++) begin
      drive(~(4'b0001 << d), pats[d]);
      for (int j = 0; j < 40; j++) begin
        step();
        if (frame_done === 1'b1) pulses++;
        if (d == 3 && (j == 6 || j == 7)) begin
          tests++;
          if (frame_done !== (j == 7)) begin
            fails++;
            $display("FAIL scan_pulse_timing j=%0d: got %b required %b", j, frame_done, (j == 7));
          end
        end
        tests++;
        if ({digits, digit_valid, pattern_err, frame_done, stale} !== {exp_digits, exp_valid, exp_perr, exp_fd, exp_stale}) begin
          fails++;
          $display("FAIL scan_model d=%0d j=%0d: got %h required %h", d, j,
                   {digits, digit_valid, pattern_err, frame_done, stale}, {exp_digits, exp_valid, exp_perr, exp_fd, exp_stale});
        end
      end
    end
    tests++;
    if (digits !== 16'hDA71 || digit_valid !== 4'b1111 || pulses != 1) begin
      fails++;
      $display("FAIL scan_result: digits=%h valid=%b pulses=%0d required DA71 1111 1", digits, digit_valid, pulses);
    end
  endtask

  task automatic test_glitch();
    drive(4'b1101, 7'h6D);
    for (int j = 0; j < 25; j++) begin
      if (j == 3) drive(4'b1101, 7'h7D);
      step();
      tests++;
      if (digits[7:4] === 4'h5) begin
        fails++;
        $display("FAIL glitch_leak j=%0d: digit1 got 5 required not 5", j);
      end
    end
    tests++;
    if (digits[7:4] !== 4'h6 || digit_valid[1] !== 1'b1) begin
      fails++;
      $display("FAIL glitch_final: digit1=%h valid1=%b required 6 and 1", digits[7:4], digit_valid[1]);
    end
  endtask

  task automatic test_illegal_blank();
    drive(4'b1011, 7'h4F);
    for (int j = 0; j < 20; j++) step();
    drive(4'b1011, 7'h55);
    for (int j = 0; j < 20; j++) step();
    tests++;
    if (pattern_err[2] !== 1'b1 || digit_valid[2] !== 1'b0 || digits[11:8] !== 4'h3) begin
      fails++;
      $display("FAIL illegal: perr2=%b valid2=%b digit2=%h required 1 0 3", pattern_err[2], digit_valid[2], digits[11:8]);
    end
    drive(4'b1011, 7'h00);
    for (int j = 0; j < 20; j++) step();
    tests++;
    if (pattern_err[2] !== 1'b0 || digit_valid[2] !== 1'b0 || digits[11:8] !== 4'h3) begin
      fails++;
      $display("FAIL blank: perr2=%b valid2=%b digit2=%h required 0 0 3", pattern_err[2], digit_valid[2], digits[11:8]);
    end
    tests++;
    if ({digits, digit_valid, pattern_err, frame_done, stale} !== {exp_digits, exp_valid, exp_perr, exp_fd, exp_stale}) begin
      fails++;
      $display("FAIL illegal_model: got %h required %h",
               {digits, digit_valid, pattern_err, frame_done, stale}, {exp_digits, exp_valid, exp_perr, exp_fd, exp_stale});
    end
  endtask

  task automatic test_stale_and_reset();
    logic [4*NDIG-1:0] d_before;
    logic [NDIG-1:0]   v_before;
    // Two anodes at once must never capture.
    d_before = digits;
    v_before = digit_valid;
    drive(4'b1100, 7'h06);
    for (int j = 0; j < 50; j++) step();
    tests++;
    if (digits !== d_before || digit_valid !== v_before) begin
      fails++;
      $display("FAIL multihot: digits=%h valid=%b required %h %b", digits, digit_valid, d_before, v_before);
    end
    // Reset in the middle of a dwell.
    do_reset();
    for (int j = 0; j < 3; j++) step();
    drive(4'b0111, 7'h5B);
    for (int e = 0; e <= 4; e++) step();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({digits, digit_valid, pattern_err, frame_done, stale} !== 26'd0) begin
      fails++;
      $display("FAIL middwell_reset: got %h required 0", {digits, digit_valid, pattern_err, frame_done, stale});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step();
      tests++;
      if (digit_valid[3] !== (e == 6)) begin
        fails++;
        $display("FAIL middwell_recapture e=%0d: valid3 got %b required %b", e, digit_valid[3], (e == 6));
      end
    end
    // Stale onset and recovery.
    drive(4'b1111, 7'h00);
    for (int j = 0; j < TIMEOUT_CYC + 10; j++) step();
    tests++;
    if (stale !== 1'b1 || digit_valid !== 4'b0000 || digits[15:12] !== 4'h2) begin
      fails++;
      $display("FAIL stale_hold: stale=%b valid=%b digit3=%h required 1 0000 2", stale, digit_valid, digits[15:12]);
    end
    drive(4'b1101, 7'h66);
    for (int e = 0; e <= 6; e++) begin
      step();
      if (e >= 5) begin
        tests++;
        if (stale !== (e == 5) || digit_valid !== ((e == 6) ? 4'b0010 : 4'b0000)) begin
          fails++;
          $display("FAIL stale_recover e=%0d: stale=%b valid=%b", e, stale, digit_valid);
        end
      end
    end
    tests++;
    if (digits[7:4] !== 4'h4) begin
      fails++;
      $display("FAIL stale_recover_digit: got %h required 4", digits[7:4]);
    end
  endtask

  task automatic test_random();
    logic [6:0] p;
    logic [3:0] a;
    int hold;
    int sel;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 14)      p = PAT[$urandom_range(0, 17)];
      else if (sel < 17) p = 7'h00;
      else               p = 7'($urandom);
      if ($urandom_range(0, 9) < 8) a = ~(4'b0001 << $urandom_range(0, 3));
      else                          a = 4'($urandom);
      drive(a, p);
      hold = $urandom_range(1, 10);
      for (int j = 0; j < hold; j++) begin
        step();
        tests++;
        if ({digits, digit_valid, pattern_err, frame_done, stale} !== {exp_digits, exp_valid, exp_perr, exp_fd, exp_stale}) begin
          fails++;
          $display("FAIL random_model n=%0d: got %h required %h", n,
                   {digits, digit_valid, pattern_err, frame_done, stale}, {exp_digits, exp_valid, exp_perr, exp_fd, exp_stale});
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    anode_L = 4'b1111;
    seg_L   = 7'h7F;
    test_reset();
    test_latency();
    test_scan();
    test_glitch();
    test_illegal_blank();
    test_stale_and_reset();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
